uart_tx_ctrl: RTL
=================

# uart_tx_ctrl

Buffered UART transmit controller sitting between the CPU store path and the top-level `uart_tx` pin. The CPU pushes bytes through a single-cycle write strobe into a small FIFO. The controller drains the FIFO and serialises each byte as 8N1, LSB first, at a fixed baud divisor. Busy, full and sticky overflow status are exposed so software can poll before writing.

## Interface
- `CLKS_PER_BIT`, 868: sysclk cycles per UART bit; legal range 2..65535.
- `FIFO_AW`, 4: FIFO address width; depth = 2**FIFO_AW (default 16).
- `sysclk`  in  1  system clock; all state changes on its rising edge.
- `cpu_resetn`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  push strobe; one byte per cycle while high.
- `wr_data`  in  8  byte to push; sampled when `wr_en`=1.
- `clr_ovf`  in  1  clears `overflow`.
- `full`  out  1  FIFO holds 2**FIFO_AW bytes.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `overflow`  out  1  sticky; a write was dropped.
- `fifo_count`  out  FIFO_AW+1  bytes currently buffered (0..2**FIFO_AW).
- `uart_tx`  out  1  serial line, idle high, registered.

## Operation
- Reset values: `uart_tx`=1, `full`=0, `busy`=0, `overflow`=0, `fifo_count`=0. FSM starts in IDLE. Read/write pointers, baud counter and bit index are all 0.
- FIFO is a circular buffer. Pointers have FIFO_AW bits and wrap naturally from 2**FIFO_AW-1 to 0.
- Push: accepted when `wr_en`=1 and `full`=0.
- Dropped write: `wr_en`=1 with `full`=1 does not change FIFO contents and sets `overflow`.
- Pop: performed by the FSM only, on IDLE->START or STOP->START.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged. When full, a write in a pop cycle is still dropped, because `full` is evaluated before the pop.
- `overflow`: when a set and `clr_ovf` occur in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `uart_tx`=1. If `fifo_count`!=0, pop the head byte into the shift register and go to START.
- START: `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: `uart_tx`=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit 7, go to STOP.
- STOP: `uart_tx`=1 for CLKS_PER_BIT cycles. At the end of STOP, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, resets to 0 on every state change, 16 bits wide.
- `busy` = (state != IDLE) or (`fifo_count` != 0).
- `full` = (`fifo_count` == 2**FIFO_AW).
- Reset asserted mid-frame: `uart_tx` goes to 1 immediately (asynchronous), the FIFO is emptied and the partial frame is abandoned. No frame is resumed after reset release.

## Timing
- Registered outputs: `uart_tx`, `fifo_count`, `full`, `overflow`, `busy`. All update on the edge following the causing event.
- Latency: `wr_en` sampled at edge k into an empty FIFO with FSM in IDLE gives `fifo_count`=1 after edge k. The pop occurs and `uart_tx` falls after edge k+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the falling start edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Write acceptance: `full` reflects the state before the current edge, so software must sample `full`=0 in the same cycle as `wr_en`.
- Clear timing: `clr_ovf` takes effect at the next edge.

## Test plan
- Single byte: CLKS_PER_BIT=4, write 0x55 at edge k -> `uart_tx` low after k+1. The line then shows 1,0,1,0,1,0,1,0 for 4 cycles each, then stop high. `busy` falls 40 cycles after the start bit began.
- Back-to-back: write 0xA5 then 0x0F on consecutive cycles -> two frames totalling 80 cycles with no high gap between stop and second start. Decoded bytes are 0xA5 then 0x0F.
- Fill and overflow: with FSM held busy, write 17 bytes back-to-back -> `full`=1 after the 16th write (counting pops). The 17th write is dropped and `overflow`=1. All 16 buffered bytes are transmitted in order, including across pointer wrap.
- Overflow priority: `clr_ovf`=1 in the same cycle as a dropped write -> `overflow` stays 1. A `clr_ovf` pulse alone then clears it to 0.
- Push/pop collision: FIFO holds 3 bytes, write a byte on the STOP->START pop cycle -> `fifo_count` stays 3. Data order is preserved.
- Reset mid-frame: assert `cpu_resetn`=0 during DATA bit 3 -> `uart_tx`=1 without waiting for a clock edge. After release: `fifo_count`=0, `busy`=0, no further frames.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// Buffered 8N1 UART transmitter: CPU pushes bytes into a circular FIFO and the FSM
// drains it LSB-first at a fixed baud divisor, with back-to-back frames and no idle gap.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic               sysclk,
  input  logic               cpu_resetn,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               clr_ovf,
  output logic               full,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               uart_tx,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int               DEPTH_I = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW+1)'(DEPTH_I);
  localparam logic [15:0]      BIT_END = 16'(CLKS_PER_BIT - 1);

  logic [7:0]         fifo_mem_q [DEPTH_I];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [1:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               full_q, full_d, busy_q, busy_d, ovf_q, ovf_d, tx_q, tx_d;
  logic               push, pop, bit_end;

  always_comb begin
    // full_q is the pre-edge view, so a write in a pop cycle is still dropped when full
    push    = wr_en && !full_q;
    pop     = 1'b0;
    bit_end = (cnt_q == BIT_END);
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (pop) shift_d = fifo_mem_q[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (wr_en && full_q)  ovf_d = 1'b1;
    else if (clr_ovf)     ovf_d = 1'b0;
    else                  ovf_d = ovf_q;

    full_d = (count_d == DEPTH);
    busy_d = (state_d != IDLE) || (count_d != '0);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge sysclk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= wr_data;
  end

  assign full       = full_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;
  assign uart_tx    = tx_q;
  assign dbg_state  = state_q;

endmodule
